// File: rtl/uart_tx_shift_register.sv
// UART transmitter: one-byte holding register feeding a start/8N/stop frame shifter.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx_shift_register #(
   parameter int unsigned CLKS_PER_BIT = 434,
   parameter int unsigned CNT_W        = 16
) (
   input  logic       CLOCK,
   input  logic       reset,
   input  logic [7:0] tx_data_in,
   input  logic       Wr_en,
   input  logic       clr_ovrflw,
   output logic       Tx,
   output logic       tx_ready,
   output logic       busy,
   output logic       overflow
);

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StStop
`ifdef UART_TX_PARITY_EN
      , StParity
`endif
   } state_e;

   localparam logic [CNT_W-1:0] CntLast = CNT_W'(CLKS_PER_BIT - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       idx_q, idx_d;
   logic [7:0]       shift_q, shift_d;
   logic [7:0]       hold_q, hold_d;
   logic             full_q, full_d;
   logic             ovf_q, ovf_d;
   logic             tx_q, tx_d;
   logic             bit_end;
   logic             load;
`ifdef UART_TX_PARITY_EN
   logic             parity_q, parity_d;
`endif

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      shift_d  = shift_q;
      hold_d   = hold_q;
      full_d   = full_q;
      ovf_d    = ovf_q;
      load     = 1'b0;
      bit_end  = (cnt_q == CntLast);
`ifdef UART_TX_PARITY_EN
      parity_d = parity_q;
`endif

      if (state_q != StIdle) begin
         cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
      end

      unique case (state_q)
         StIdle: begin
            if (full_q) load = 1'b1;
         end
         StStart: begin
            if (bit_end) begin
               state_d = StData;
               idx_d   = 3'd0;
            end
         end
         StData: begin
            if (bit_end) begin
               shift_d = shift_q >> 1;
               if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_d = StParity;
`else
                  state_d = StStop;
`endif
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         StParity: begin
            if (bit_end) state_d = StStop;
         end
`endif
         StStop: begin
            // A queued byte chains straight into the next start bit.
            if (bit_end) begin
               if (full_q) load = 1'b1;
               else        state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase

      if (load) begin
         state_d  = StStart;
         shift_d  = hold_q;
         full_d   = 1'b0;
         cnt_d    = '0;
`ifdef UART_TX_PARITY_EN
         parity_d = ^hold_q;
`endif
      end

      // Acceptance uses the pre-edge full flag, so a write racing a load is dropped.
      if (Wr_en) begin
         if (full_q) begin
            ovf_d = 1'b1;
         end else begin
            hold_d = tx_data_in;
            full_d = 1'b1;
         end
      end
      if (clr_ovrflw) ovf_d = 1'b0;

      case (state_d)
         StStart:  tx_d = 1'b0;
         StData:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
         StParity: tx_d = parity_d;
`endif
         default:  tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge CLOCK) begin
      if (!reset) begin
         state_q  <= StIdle;
         cnt_q    <= '0;
         idx_q    <= 3'd0;
         shift_q  <= 8'h00;
         hold_q   <= 8'h00;
         full_q   <= 1'b0;
         ovf_q    <= 1'b0;
         tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         shift_q  <= shift_d;
         hold_q   <= hold_d;
         full_q   <= full_d;
         ovf_q    <= ovf_d;
         tx_q     <= tx_d;
`ifdef UART_TX_PARITY_EN
         parity_q <= parity_d;
`endif
      end
   end

   assign Tx       = tx_q;
   assign tx_ready = ~full_q;
   assign busy     = (state_q != StIdle);
   assign overflow = ovf_q;

endmodule

// File: tb/tb_uart_tx_shift_register.sv
// Bench for uart_tx_shift_register: directed writes, expected bytes queued, serial monitor checks frames.
module tb_uart_tx_shift_register;

   localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif
   localparam int FRAME = NBITS * CPB;

   logic       CLOCK;
   logic       reset;
   logic [7:0] tx_data_in;
   logic       Wr_en;
   logic       clr_ovrflw;
   logic       Tx;
   logic       tx_ready;
   logic       busy;
   logic       overflow;

   int         n_cmp = 0;
   int         n_err = 0;
   int         cyc = 0;
   int         frames_done = 0;
   logic [7:0] exp_q[$];
   int         start_q[$];

   uart_tx_shift_register #(
      .CLKS_PER_BIT(CPB),
      .CNT_W       (16)
   ) dut (
      .CLOCK     (CLOCK),
      .reset     (reset),
      .tx_data_in(tx_data_in),
      .Wr_en     (Wr_en),
      .clr_ovrflw(clr_ovrflw),
      .Tx        (Tx),
      .tx_ready  (tx_ready),
      .busy      (busy),
      .overflow  (overflow)
   );

   initial begin
      CLOCK = 1'b0;
      forever #5 CLOCK = ~CLOCK;
   end

   always @(posedge CLOCK) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge CLOCK);
      #1;
   endtask

   // Drive a one-cycle write; queue the byte only when it is expected to go out.
   task automatic wr(input logic [7:0] b, input bit sent);
      tx_data_in = b;
      Wr_en      = 1'b1;
      if (sent) exp_q.push_back(b);
      tick(1);
      Wr_en      = 1'b0;
   endtask

   task automatic wait_frames(input int target);
      for (int i = 0; i < 4000 && frames_done < target; i++) tick(1);
      check("frame_count", frames_done, target);
      tick(2);
   endtask

   // Serial monitor: a low Tx outside a frame starts one; every sample is checked, reset aborts.
   initial begin
      logic       s[FRAME];
      logic       exp_bits[NBITS];
      logic [7:0] e;
      logic [7:0] got;
      int         bad;
      bit         aborted;
      forever begin
         @(negedge CLOCK);
         if (reset === 1'b1 && Tx === 1'b0) begin
            start_q.push_back(cyc);
            aborted = 0;
            for (int i = 0; i < FRAME; i++) begin
               if (i > 0) @(negedge CLOCK);
               if (reset !== 1'b1) begin
                  aborted = 1;
                  break;
               end
               s[i] = Tx;
            end
            if (!aborted) begin
               frames_done++;
               got = 8'h00;
               for (int k = 0; k < 8; k++) got[k] = s[(k + 1) * CPB + CPB / 2];
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_err++;
                  $display("FAIL unexpected_frame: got byte %02h expected no frame", got);
               end else begin
                  e = exp_q.pop_front();
                  exp_bits[0] = 1'b0;
                  for (int k = 0; k < 8; k++) exp_bits[k + 1] = e[k];
`ifdef UART_TX_PARITY_EN
                  exp_bits[9] = ^e;
`endif
                  exp_bits[NBITS - 1] = 1'b1;
                  bad = 0;
                  for (int i = 0; i < FRAME; i++) if (s[i] !== exp_bits[i / CPB]) bad++;
                  n_cmp++;
                  if (bad != 0 || got !== e) begin
                     n_err++;
                     $display("FAIL frame: got byte %02h (%0d bad samples) expected byte %02h",
                              got, bad, e);
                  end
               end
            end
         end
      end
   end

   initial begin
      int t0;
      reset      = 1'b0;
      Wr_en      = 1'b1;
      tx_data_in = 8'h55;
      clr_ovrflw = 1'b0;

      // Reset with a write held active: nothing may be captured.
      tick(3);
      check("rst_tx", Tx, 1);
      check("rst_ready", tx_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_ovf", overflow, 0);
      reset = 1'b1;
      Wr_en = 1'b0;
      tick(10);
      check("post_rst_busy", busy, 0);
      check("post_rst_frames", frames_done, 0);

      // Single frame 0xA5 from idle: latency and frame length.
      wr(8'hA5, 1);
      check("wr_ready_lat", tx_ready, 0);
      check("wr_busy_lat", busy, 0);
      check("wr_tx_lat", Tx, 1);
      tick(1);
      check("xfer_ready", tx_ready, 1);
      check("xfer_busy", busy, 1);
      check("start_tx", Tx, 0);
      tick(FRAME - 1);
      check("busy_last_cycle", busy, 1);
      tick(1);
      check("busy_drop", busy, 0);
      wait_frames(1);

      // Back-to-back: second write during START of the first frame.
      start_q.delete();
      wr(8'h3C, 1);
      tick(1);
      wr(8'hC3, 1);
      check("b2b_ovf_early", overflow, 0);
      wait_frames(3);
      check("b2b_ovf", overflow, 0);
      t0 = (start_q.size() >= 2) ? start_q[1] - start_q[0] : -1;
      check("b2b_gap", t0, FRAME);

      // Consecutive writes: the second hits a full register (emptying that same cycle).
      wr(8'h11, 1);
      wr(8'h22, 0);
      wr(8'h33, 1);
      check("ovf_set", overflow, 1);
      check("full_ready", tx_ready, 0);
      clr_ovrflw = 1'b1;
      wr(8'h44, 0);
      clr_ovrflw = 1'b0;
      check("ovf_clr_priority", overflow, 0);
      wait_frames(5);

      // Reset mid-frame at the midpoint of data bit 3.
      wr(8'hFF, 0);
      tick(1 + CPB + 3 * CPB + CPB / 2 - 1);
      check("mid_tx_bit3", Tx, 1);
      reset = 1'b0;
      tick(1);
      check("abort_tx", Tx, 1);
      check("abort_ready", tx_ready, 1);
      check("abort_busy", busy, 0);
      reset = 1'b1;
      tick(2);
      wr(8'h00, 1);
      wait_frames(6);

`ifdef UART_TX_PARITY_EN
      wr(8'h07, 1);
      wait_frames(7);
      wr(8'h03, 1);
      wait_frames(8);
`endif

      check("queue_empty", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
